matmul_tile_ctrl: RTL and testbench

Parametrised sequencer for the systolic matrix-multiplication kernel. It computes C = A·B for rectangular operands (A is ROWS×K, B is K×COLS) on an N1×N2 array by walking output tiles. For each tile it issues the operand-bank read addresses for A and B, then waits out the array skew, then signals a result write. It adds a start/done handshake, operand stall and per-tile accumulator clear, none of which the free-running address counters provide.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/matmul_tile_counter.sv | 76 +++++++
 rtl/matmul_tile_ctrl.sv | 134 +++++++++++++
 tb/tb_matmul_tile_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types, defaults and width helper for the systolic matmul tile sequencer.
package matmul_pkg;

  localparam int unsigned DefaultN1 = 4;
  localparam int unsigned DefaultN2 = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StWrite,
    StDone
  } state_e;

  // Counter/address width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2w(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/matmul_tile_counter.sv
// Nested k / tile_col / tile_row counter with wrap flags.
// k and the tile pair advance independently; the caller sequences them.
module tile_counter
  import matmul_pkg::*;
#(
  parameter int unsigned KDim     = 8,
  parameter int unsigned TileCols = 2,
  parameter int unsigned TileRows = 2,
  localparam int unsigned KW = clog2w(KDim),
  localparam int unsigned CW = clog2w(TileCols),
  localparam int unsigned RW = clog2w(TileRows)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          k_en_i,
  input  logic          tile_en_i,
  output logic [KW-1:0] k_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          k_last_o,
  output logic          col_last_o,
  output logic          row_last_o
);

  localparam logic [KW-1:0] KMax   = KW'(KDim - 1);
  localparam logic [CW-1:0] ColMax = CW'(TileCols - 1);
  localparam logic [RW-1:0] RowMax = RW'(TileRows - 1);

  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign k_last_o   = (k_q == KMax);
  assign col_last_o = (col_q == ColMax);
  assign row_last_o = (row_q == RowMax);
  assign k_o        = k_q;
  assign col_o      = col_q;
  assign row_o      = row_q;

  always_comb begin
    k_d   = k_q;
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      k_d   = '0;
      col_d = '0;
      row_d = '0;
    end else begin
      if (k_en_i) begin
        k_d = k_last_o ? '0 : k_q + 1'b1;
      end
      if (tile_en_i) begin
        if (col_last_o) begin
          col_d = '0;
          row_d = row_last_o ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q   <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      k_q   <= k_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/matmul_tile_ctrl.sv
// Tile sequencer for the systolic matmul array: issues A/B operand addresses per
// output tile, drains the array skew, then flags the tile result write.
module matmul_tile_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned N1    = DefaultN1,
  parameter int unsigned N2    = DefaultN2,
  parameter int unsigned ROWS  = 8,
  parameter int unsigned K     = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned FLUSH = N1 + N2 - 1,
  localparam int unsigned TR  = ROWS / N1,
  localparam int unsigned TC  = COLS / N2,
  localparam int unsigned AwA = clog2w(TR * K),
  localparam int unsigned AwB = clog2w(TC * K),
  localparam int unsigned AwO = clog2w(TR * TC)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           stall_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           rd_en_o,
  output logic [AwA-1:0] rd_addr_a_o,
  output logic [AwB-1:0] rd_addr_b_o,
  output logic           acc_clear_o,
  output logic           out_valid_o,
  output logic [AwO-1:0] out_addr_o
);

  localparam int unsigned KW = clog2w(K);
  localparam int unsigned CW = clog2w(TC);
  localparam int unsigned RW = clog2w(TR);
  localparam int unsigned FW = clog2w(FLUSH);
  // FLUSH is assumed to be at least 1 (default N1+N2-1).
  localparam logic [FW-1:0] FlushMax = FW'(FLUSH - 1);

  state_e        state_q, state_d;
  logic [FW-1:0] flush_q, flush_d;

  logic          cnt_clear, k_en, tile_en;
  logic [KW-1:0] k;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          k_last, col_last, row_last;

  tile_counter #(
    .KDim    (K),
    .TileCols(TC),
    .TileRows(TR)
  ) u_tile_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (cnt_clear),
    .k_en_i    (k_en),
    .tile_en_i (tile_en),
    .k_o       (k),
    .col_o     (col),
    .row_o     (row),
    .k_last_o  (k_last),
    .col_last_o(col_last),
    .row_last_o(row_last)
  );

  // Constant-times-counter products; no runtime multiplier.
  assign rd_addr_a_o = AwA'(32'(row) * K + 32'(k));
  assign rd_addr_b_o = AwB'(32'(col) * K + 32'(k));
  assign out_addr_o  = AwO'(32'(row) * TC + 32'(col));

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    cnt_clear   = 1'b0;
    k_en        = 1'b0;
    tile_en     = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    rd_en_o     = 1'b0;
    acc_clear_o = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_clear = 1'b1;
          flush_d   = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        busy_o = 1'b1;
        if (!stall_i) begin
          rd_en_o     = 1'b1;
          acc_clear_o = (k == '0);
          k_en        = 1'b1;
          if (k_last) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        busy_o = 1'b1;
        if (flush_q == FlushMax) begin
          flush_d = '0;
          state_d = StWrite;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      StWrite: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        tile_en     = 1'b1;
        state_d     = (row_last && col_last) ? StDone : StLoad;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// Self-checking bench: three parameterisations, a per-cycle reference trace built
// from tile/k loops, scenario table, held start, mid-job reset and random stall.
module tb_matmul_tile_ctrl;
  import matmul_pkg::*;

  typedef struct {
    int n1, n2, rows, k, cols, flush;
  } cfg_t;

  typedef struct {
    bit busy, done, rd, clr, ov, chk_addr;
    int a, b, o;
  } rec_t;

  typedef struct {
    int cfg, stall_at, stall_len, exp_busy, exp_first_ov, exp_done, exp_tiles;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_r, stall_r;
  int   sel;

  always #5 clk = ~clk;

  cfg_t cfgs[3];
  vec_t vecs[4];
  bit   stall_pat[4096];
  rec_t exp_q[$];
  int   checks, errors;
  int   busy_cnt, first_ov, done_at, tiles_seen;

  // DUT 0: defaults. DUT 1: rectangular. DUT 2: K=1.
  logic b0, d0, r0, c0, v0;
  logic [clog2w(16)-1:0] a0, bb0;
  logic [clog2w(4)-1:0]  o0;
  logic b1, d1, r1, c1, v1;
  logic [clog2w(9)-1:0]  a1;
  logic [clog2w(3)-1:0]  bb1, o1;
  logic b2, d2, r2, c2, v2;
  logic [0:0]            a2, bb2;
  logic [clog2w(4)-1:0]  o2;

  matmul_tile_ctrl u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r && sel == 0), .stall_i(stall_r && sel == 0),
    .busy_o(b0), .done_o(d0), .rd_en_o(r0), .rd_addr_a_o(a0), .rd_addr_b_o(bb0),
    .acc_clear_o(c0), .out_valid_o(v0), .out_addr_o(o0)
  );

  matmul_tile_ctrl #(.N1(2), .N2(4), .ROWS(6), .K(3), .COLS(4), .FLUSH(5)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r && sel == 1), .stall_i(stall_r && sel == 1),
    .busy_o(b1), .done_o(d1), .rd_en_o(r1), .rd_addr_a_o(a1), .rd_addr_b_o(bb1),
    .acc_clear_o(c1), .out_valid_o(v1), .out_addr_o(o1)
  );

  matmul_tile_ctrl #(.N1(4), .N2(4), .ROWS(8), .K(1), .COLS(8)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r && sel == 2), .stall_i(stall_r && sel == 2),
    .busy_o(b2), .done_o(d2), .rd_en_o(r2), .rd_addr_a_o(a2), .rd_addr_b_o(bb2),
    .acc_clear_o(c2), .out_valid_o(v2), .out_addr_o(o2)
  );

  rec_t obs;
  always_comb begin
    obs = '{default: 0};
    case (sel)
      0: obs = '{b0, d0, r0, c0, v0, 1'b0, int'(a0), int'(bb0), int'(o0)};
      1: obs = '{b1, d1, r1, c1, v1, 1'b0, int'(a1), int'(bb1), int'(o1)};
      default: obs = '{b2, d2, r2, c2, v2, 1'b0, int'(a2), int'(bb2), int'(o2)};
    endcase
  end

  function automatic rec_t mk(bit busy, bit done, bit rd, bit clr, bit ov, bit chk,
                              int a, int b, int o);
    rec_t r;
    r = '{busy, done, rd, clr, ov, chk, a, b, o};
    return r;
  endfunction

  // Expected trace, one record per cycle after the start edge.
  task automatic build(input cfg_t c);
    int s;
    int tr;
    int tc;
    s  = 0;
    tr = c.rows / c.n1;
    tc = c.cols / c.n2;
    exp_q.delete();
    for (int row = 0; row < tr; row++) begin
      for (int col = 0; col < tc; col++) begin
        for (int kk = 0; kk < c.k; kk++) begin
          while (stall_pat[s]) begin
            exp_q.push_back(mk(1, 0, 0, 0, 0, 1, row * c.k + kk, col * c.k + kk, 0));
            s++;
          end
          exp_q.push_back(mk(1, 0, 1, kk == 0, 0, 1, row * c.k + kk, col * c.k + kk, 0));
          s++;
        end
        for (int f = 0; f < c.flush; f++) begin
          exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
          s++;
        end
        exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, row * tc + col));
        s++;
      end
    end
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic check_cycle(input string name, input int idx, input rec_t e);
    bit ok;
    checks++;
    ok = (obs.busy == e.busy) && (obs.done == e.done) && (obs.rd == e.rd) &&
         (obs.clr == e.clr) && (obs.ov == e.ov);
    if (e.chk_addr) ok = ok && (obs.a == e.a) && (obs.b == e.b);
    if (e.ov) ok = ok && (obs.o == e.o);
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle %0d: got busy=%0b done=%0b rd_en=%0b clr=%0b ov=%0b a=%0d b=%0d o=%0d; want busy=%0b done=%0b rd_en=%0b clr=%0b ov=%0b a=%0d b=%0d o=%0d",
               name, idx, obs.busy, obs.done, obs.rd, obs.clr, obs.ov, obs.a, obs.b, obs.o,
               e.busy, e.done, e.rd, e.clr, e.ov, e.a, e.b, e.o);
    end
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_pat();
    foreach (stall_pat[i]) stall_pat[i] = 1'b0;
  endtask

  // Entered and left #1 after a rising edge with the selected DUT idle.
  task automatic run_job(input int cfg_i, input bit hold, input int abort_at, input string name);
    sel = cfg_i;
    build(cfgs[cfg_i]);
    busy_cnt   = 0;
    first_ov   = -1;
    done_at    = -1;
    tiles_seen = 0;
    start_r    = 1'b1;
    stall_r    = 1'($urandom);
    @(negedge clk);
    check_cycle({name, "_idle"}, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      start_r = hold ? 1'b1 : 1'($urandom);
      stall_r = stall_pat[i];
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_cycle({name, "_rst_now"}, i + 1, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        check_cycle({name, "_rst_hold"}, i + 1, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        return;
      end
      @(negedge clk);
      check_cycle(name, i + 1, exp_q[i]);
      if (obs.busy) busy_cnt++;
      if (obs.ov) tiles_seen++;
      if (obs.ov && first_ov < 0) first_ov = i + 1;
      if (obs.done && done_at < 0) done_at = i + 1;
      @(posedge clk);
    end
    #1;
    start_r = hold;
    stall_r = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start_r = 1'b0;
    stall_r = 1'b0;
    sel     = 0;
    cfgs[0] = '{4, 4, 8, 8, 8, 7};
    cfgs[1] = '{2, 4, 6, 3, 4, 5};
    cfgs[2] = '{4, 4, 8, 1, 8, 7};
    //         cfg stall_at len busy first_ov done tiles
    vecs[0] = '{0, -1, 0, 64, 16, 65, 4};
    vecs[1] = '{0, 4, 3, 67, 19, 68, 4};
    vecs[2] = '{1, -1, 0, 27, 9, 28, 3};
    vecs[3] = '{2, -1, 0, 36, 9, 37, 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      check_cycle("reset_state", d, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    end
    sel   = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[v]) begin
      clear_pat();
      for (int i = 0; i < vecs[v].stall_len; i++) stall_pat[vecs[v].stall_at + i] = 1'b1;
      run_job(vecs[v].cfg, 1'b0, -1, $sformatf("vec%0d", v));
      check_eq($sformatf("vec%0d_busy_cycles", v), busy_cnt, vecs[v].exp_busy);
      check_eq($sformatf("vec%0d_first_out_valid", v), first_ov, vecs[v].exp_first_ov);
      check_eq($sformatf("vec%0d_done_cycle", v), done_at, vecs[v].exp_done);
      check_eq($sformatf("vec%0d_tiles", v), tiles_seen, vecs[v].exp_tiles);
    end

    // start held high: second job begins from the IDLE cycle after done.
    clear_pat();
    run_job(0, 1'b1, -1, "held_a");
    run_job(0, 1'b1, -1, "held_b");
    check_eq("held_b_done_cycle", done_at, 65);
    start_r = 1'b0;

    // Reset during the FLUSH of tile 2 (cycle index 42), then a clean restart.
    run_job(0, 1'b0, 42, "abort");
    start_r = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_cycle("after_reset_idle", 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    end
    @(posedge clk);
    #1;
    run_job(0, 1'b0, -1, "restart");
    check_eq("restart_done_cycle", done_at, 65);

    for (int j = 0; j < 9; j++) begin
      int gap;
      clear_pat();
      for (int i = 0; i < 300; i++) stall_pat[i] = ($urandom_range(0, 3) == 0);
      run_job(j % 3, 1'b0, -1, $sformatf("rand%0d", j));
      start_r = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end

    @(negedge clk);
    check_cycle("final_idle", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
